// File: rtl/ccff_bitstream_loader.sv
// Byte-wide bitstream feeder for the configuration chain: accepts bytes over valid/ready
// and serialises them MSB-first onto ccff_head, stopping after exactly NUM_BITS shifts.
module ccff_bitstream_loader #(
    parameter int NUM_BITS = 1024,
    parameter int CNT_W    = $clog2(NUM_BITS + 1)
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    output logic             prog_busy,
    output logic             prog_done,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS);

    state_t      state;
    logic [7:0]  shreg;      // bits of the current byte not yet presented on ccff_head
    logic [3:0]  byte_left;  // how many of those bits still belong to the chain
    logic [31:0] bits_remaining;
    logic [3:0]  byte_len;
    logic [CNT_W-1:0] count_next;

    // Bits the accepted byte contributes: a full byte, or the tail of a partial last byte.
    always_comb begin
        bits_remaining = 32'(NUM_BITS) - 32'(bit_count);
        byte_len       = (bits_remaining >= 32'd8) ? 4'd8 : bits_remaining[3:0];
        count_next     = (bit_count == LAST_BIT) ? bit_count : bit_count + CNT_W'(1);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples the
    // pre-edge values; blocking here would let later statements see half-updated state.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state         <= IDLE;
            byte_ready    <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            prog_busy     <= 1'b0;
            prog_done     <= 1'b0;
            bit_count     <= '0;
            shreg         <= '0;
            byte_left     <= '0;
        end else begin
            ccff_shift_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        byte_ready <= 1'b1;
                        prog_busy  <= 1'b1;
                        prog_done  <= 1'b0;
                        bit_count  <= '0;
                    end
                end
                LOAD: begin
                    // The first bit goes out on the accepting edge so shifting starts next cycle.
                    if (byte_valid && byte_ready) begin
                        state         <= SHIFT;
                        byte_ready    <= 1'b0;
                        ccff_head     <= byte_in[7];
                        ccff_shift_en <= 1'b1;
                        shreg         <= {byte_in[6:0], 1'b0};
                        byte_left     <= byte_len - 4'd1;
                        bit_count     <= count_next;
                    end
                end
                SHIFT: begin
                    if (byte_left != 4'd0) begin
                        ccff_head     <= shreg[7];
                        ccff_shift_en <= 1'b1;
                        shreg         <= {shreg[6:0], 1'b0};
                        byte_left     <= byte_left - 4'd1;
                        bit_count     <= count_next;
                    end else if (bit_count == LAST_BIT) begin
                        state     <= DONE;
                        prog_busy <= 1'b0;
                        prog_done <= 1'b1;
                    end else begin
                        state      <= LOAD;
                        byte_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
